// File: rtl/pipe_chain.sv
// ---------------------------------------------------------------------------
// pipe_chain
//
// Elastic pipeline register chain. STAGES register stages of WIDTH-bit payload,
// each with its own valid bit, valid/ready flow control at both ends, a
// per-stage flush (kills that stage and every younger one) and a per-stage hold
// (freezes that stage and every younger one; the stage just above the frozen
// region receives a bubble). Stage 0 is the youngest; stage STAGES-1 is the
// oldest and drives the output. All stage contents are exported for
// forwarding / hazard inspection.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset, clears every stage
//   in_valid_i     upstream offers in_data_i
//   in_ready_o     chain accepts in_data_i this cycle
//   in_data_i      payload into stage 0
//   out_valid_o    oldest stage holds a valid entry
//   out_ready_i    downstream consumes out_data_o this cycle
//   out_data_o     payload of the oldest stage
//   flush_i        flush_i[k] kills stages 0..k and the input this cycle
//   hold_i         hold_i[k] freezes stages 0..k
//   stage_valid_o  valid bit of every stage
//   stage_data_o   flat payloads, stage i at [i*WIDTH +: WIDTH]
//   count_o        number of valid stages
// ---------------------------------------------------------------------------
module pipe_chain #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 4,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WIDTH-1:0]          in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WIDTH-1:0]          out_data_o,
    input  logic [STAGES-1:0]         flush_i,
    input  logic [STAGES-1:0]         hold_i,
    output logic [STAGES-1:0]         stage_valid_o,
    output logic [STAGES*WIDTH-1:0]   stage_data_o,
    output logic [CW-1:0]             count_o
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];

    logic [STAGES-1:0] frz;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] take;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_d [STAGES];
    logic              in_hs;

    // A hold or flush at stage k also affects every younger stage, so both
    // masks are suffix-ORs running from the oldest stage downwards.
    always_comb begin
        frz  = '0;
        kill = '0;
        frz[STAGES-1]  = hold_i[STAGES-1];
        kill[STAGES-1] = flush_i[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            frz[i]  = frz[i+1]  | hold_i[i];
            kill[i] = kill[i+1] | flush_i[i];
        end
    end

    // Ready ripples combinationally from the output back to the input, so a
    // bubble anywhere in the chain is collapsed in the same cycle.
    always_comb begin
        adv  = '0;
        take = '0;
        adv[STAGES-1]  = v_q[STAGES-1] & out_ready_i & ~frz[STAGES-1];
        take[STAGES-1] = (~v_q[STAGES-1] | adv[STAGES-1]) & ~frz[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i]  = v_q[i] & take[i+1] & ~frz[i];
            take[i] = (~v_q[i] | adv[i]) & ~frz[i];
        end
    end

    assign in_ready_o = take[0] & ~(|flush_i);
    assign in_hs      = in_valid_i & in_ready_o;

    // Source of each stage. An entry leaving a killed stage must not survive
    // into the stage above the flushed region; that stage gets a bubble.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_v[gi] = in_hs;
                assign src_d[gi] = in_data_i;
            end else begin : g_body
                assign src_v[gi] = adv[gi-1] & ~kill[gi-1];
                assign src_d[gi] = d_q[gi-1];
            end
            assign stage_data_o[gi*WIDTH +: WIDTH] = d_q[gi];
        end
    endgenerate

    // Next state: kill beats freeze beats take. Payload is only loaded with a
    // valid entry; a bubble leaves the old (don't-care) data in place.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < STAGES; i++) begin
            if (kill[i]) begin
                v_d[i] = 1'b0;
            end else if (frz[i]) begin
                v_d[i] = v_q[i];
            end else if (take[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    d_d[i] = src_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < STAGES; i++) begin
            count_o = count_o + CW'(v_q[i]);
        end
    end

    assign out_valid_o   = v_q[STAGES-1];
    assign out_data_o    = d_q[STAGES-1];
    assign stage_valid_o = v_q;

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised elastic pipeline register chain: STAGES stages of WIDTH-bit payload, each with a valid bit, valid/ready flow control at both ends, per-stage flush and per-stage hold with bubble insertion. It sits between core pipeline phases as the reusable successor to the fixed IF/ID, ID/EX, EX/MEM, MEM/WB latches. Stage contents are exported so the forwarding and hazard logic can inspect every in-flight entry.

## Interface
- WIDTH, 32, payload bits per stage (>=1)
- STAGES, 4, number of register stages (>=1); stage 0 youngest, stage STAGES-1 oldest, drives output
- CW, $clog2(STAGES+1), width of occupancy count (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  WIDTH  payload into stage 0
- out_valid  output  1  stage STAGES-1 holds valid entry
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  WIDTH  payload of stage STAGES-1
- flush  input  STAGES  flush[k] kills stages 0..k and the input this cycle
- hold  input  STAGES  hold[k] freezes stages 0..k, bubble into stage k+1
- stage_valid  output  STAGES  valid bit of each stage
- stage_data  output  STAGES*WIDTH  flat payloads, stage i at [i*WIDTH +: WIDTH]
- count  output  CW  number of valid stages

## Operation
- State per stage i: v[i], d[i]. out_valid = v[STAGES-1], out_data = d[STAGES-1].
- frz[i] = OR of hold[j] for j>=i (any hold at this stage or older freezes it).
- kill[i] = OR of flush[j] for j>=i. flush_any = OR of flush.
- Advance: adv[STAGES-1] = v[STAGES-1] & out_ready & !frz[STAGES-1]; adv[i] = v[i] & take[i+1] & !frz[i] for i<STAGES-1.
- Take: take[i] = (!v[i] | adv[i]) & !frz[i].
- in_ready = take[0] & !flush_any. Input handshake = in_valid & in_ready.
- Next state, stage i (priority order):
  - kill[i]: v[i] <= 0 (data don't-care, keeps old value).
  - frz[i]: v[i], d[i] unchanged.
  - take[i]: v[i], d[i] <= source (stage i-1 if adv[i-1], else bubble v=0; stage 0 source is input handshake).
  - else: unchanged.
- Flush dominates hold on the same stage. Stages older than the highest flushed index advance normally; the stage directly above the flushed region receives a bubble.
- Hold never drops data: frozen stages keep contents; the first unfrozen stage drains and is refilled with a bubble.
- Output handshake with out_valid=1, out_ready=1, frz[STAGES-1]=0 removes the oldest entry. flush[STAGES-1] discards it without handshake (out_valid still shown that cycle; downstream must ignore when flush asserted).
- count = popcount(v), combinational from registers.
- Ready chain is combinational from out_ready through all stages to in_ready (bubble-collapsing, full throughput, no skid buffer).

## Timing
- Reset (reset=0): v=0, d=0 all stages; out_valid=0, out_data=0, stage_valid=0, stage_data=0, count=0, in_ready=1 once hold/flush low. Release is synchronous to next rising edge; first acceptance on first edge with reset=1.
- Latency: input handshake in cycle n -> out_valid in cycle n+STAGES with no hold/backpressure.
- Throughput: one entry per cycle when out_ready=1 continuously.
- Full: all v=1 and out_ready=0 -> in_ready=0. out_ready=1 when full -> in_ready=1 same cycle (simultaneous pop/push, count unchanged).
- Empty chain, out_ready=0: entries collapse forward; STAGES entries accepted before in_ready falls.
- Reset asserted mid-transfer: all entries lost immediately; no output handshake completes that cycle.
- flush and in_valid same cycle: input dropped, in_ready=0.

## Test plan
- STAGES=4, WIDTH=8: push 0x11,0x22,0x33 back-to-back cycles 0-2, out_ready=1 -> out_data 0x11,0x22,0x33 in cycles 4,5,6; count peaks 3.
- out_ready=0, push 0xA0..0xA5 -> 4 accepted (0xA0-0xA3), in_ready=0 from cycle 4, count=4; raise out_ready -> 0xA0 out, 0xA4 accepted same cycle, count stays 4.
- Fill stages with 0x01..0x04 (stage3=0x01), assert flush[1] one cycle -> stage_valid=4'b1100, 0x01,0x02 remain, input dropped; outputs 0x01 then 0x02 then empty.
- Stream 0x10,0x20,...; assert hold[1] for 2 cycles -> stages 0,1 frozen, stage2 receives 2 bubbles, out sequence shows 2-cycle gap, no payload lost or duplicated.
- hold[2] and flush[1] same cycle -> stages 0,1 cleared, stage2 unchanged, stage3 receives bubble.
- Pull reset low mid-stream (asynchronously, between edges) -> out_valid, count, stage_valid drop to 0 immediately; after release, push 0x5A -> out in 4 cycles.
